// File: rtl/aes_dec_arbiter.sv
// -----------------------------------------------------------------------------
// aes_dec_arbiter
//
// Round-robin front end that shares one AES decipher datapath between two
// block requesters. A granted ciphertext is latched onto core_block, the
// datapath is kicked with a one-cycle core_next pulse, and the captured
// plaintext is returned on resp_block with a per-requester valid/ready.
// Only one block is ever in flight.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   key_ready                    round keys expanded; gates new grants
//   reqN_valid/ready/block       requester N ciphertext handshake (N = 0, 1)
//   respN_valid/ready            requester N result handshake
//   resp_block                   captured plaintext, shared by both responses
//   core_next/core_block         start pulse and operand to the datapath
//   core_ready/core_result       datapath idle/done flag and output block
//   busy                         an operation is in progress
//   error                        sticky ack-timeout flag
//   ops_done                     completed responses, wraps
// -----------------------------------------------------------------------------
module aes_dec_arbiter #(
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_ready,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [127:0]         req0_block,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [127:0]         req1_block,
    output logic                 resp0_valid,
    input  logic                 resp0_ready,
    output logic                 resp1_valid,
    input  logic                 resp1_ready,
    output logic [127:0]         resp_block,
    output logic                 core_next,
    output logic [127:0]         core_block,
    input  logic                 core_ready,
    input  logic [127:0]         core_result,
    output logic                 busy,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] ops_done
);

    localparam int ACW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_RUN,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_last_grant;   // 1 after reset so requester 0 wins the first tie
    logic                   r_grant;        // requester owning the block in flight
    logic [127:0]           r_core_block;
    logic [127:0]           r_resp_block;
    logic                   r_error;
    logic [CNT_WIDTH-1:0]   r_ops_done;
    logic [ACW-1:0]         r_ack_cnt;

    logic                   w_pick;
    logic                   w_grant_ok;
    logic                   w_ack_timeout;
    logic                   w_resp_take;

    // Requester choice: a lone valid wins outright, a tie goes to the one
    // that was not served last.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        w_pick = ~r_last_grant;
        if (req0_valid && !req1_valid) begin
            w_pick = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            w_pick = 1'b1;
        end
    end

    assign w_grant_ok    = (r_state == S_IDLE) && key_ready && core_ready &&
                           (req0_valid || req1_valid);
    // Counter holds the number of ACK cycles already spent with core_ready
    // high; the last allowed one ends the wait.
    assign w_ack_timeout = (r_state == S_ACK) && core_ready &&
                           (r_ack_cnt == ACW'(ACK_TIMEOUT - 1));
    assign w_resp_take   = (r_state == S_RESP) &&
                           (r_grant ? resp1_ready : resp0_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_ok) w_state_nxt = S_START;
            S_START: w_state_nxt = S_ACK;
            S_ACK: begin
                if (!core_ready)        w_state_nxt = S_RUN;
                else if (w_ack_timeout) w_state_nxt = S_IDLE;
            end
            S_RUN:   if (core_ready) w_state_nxt = S_RESP;
            S_RESP:  if (w_resp_take) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the wide data registers are reset too, because their
            // contents are visible on ports and must read zero after reset.
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_core_block <= '0;
            r_resp_block <= '0;
            r_error      <= 1'b0;
            r_ops_done   <= '0;
            r_ack_cnt    <= '0;
        end else begin
            if (w_grant_ok) begin
                r_core_block <= w_pick ? req1_block : req0_block;
                r_grant      <= w_pick;
            end
            if (r_state == S_START) begin
                r_ack_cnt <= '0;
            end else if ((r_state == S_ACK) && core_ready) begin
                r_ack_cnt <= r_ack_cnt + ACW'(1);
            end
            // A datapath that never acknowledges forfeits the block; the
            // requester still counts as served for fairness.
            if (w_ack_timeout) begin
                r_error      <= 1'b1;
                r_last_grant <= r_grant;
            end
            if ((r_state == S_RUN) && core_ready) begin
                r_resp_block <= core_result;
            end
            if (w_resp_take) begin
                r_ops_done   <= r_ops_done + CNT_WIDTH'(1);
                r_last_grant <= r_grant;
            end
        end
    end

    assign req0_ready  = w_grant_ok && !w_pick;
    assign req1_ready  = w_grant_ok &&  w_pick;
    assign core_next   = (r_state == S_START);
    assign core_block  = r_core_block;
    assign resp0_valid = (r_state == S_RESP) && !r_grant;
    assign resp1_valid = (r_state == S_RESP) &&  r_grant;
    assign resp_block  = r_resp_block;
    assign busy        = (r_state != S_IDLE);
    assign error       = r_error;
    assign ops_done    = r_ops_done;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_arbiter
//
// Directed bench for aes_dec_arbiter. A behavioural datapath stands in for the
// decipher core: it drops core_ready one negedge after core_next, raises it
// again a few cycles later with a looked-up result, or never drops it when
// core_stuck is set.
// -----------------------------------------------------------------------------
module tb_aes_dec_arbiter;

    localparam int ACK_TIMEOUT = 4;
    localparam int CNT_WIDTH   = 16;

    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] MSK = 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;

    logic                 clk;
    logic                 reset_n;
    logic                 key_ready;
    logic                 req0_valid, req0_ready;
    logic [127:0]         req0_block;
    logic                 req1_valid, req1_ready;
    logic [127:0]         req1_block;
    logic                 resp0_valid, resp0_ready;
    logic                 resp1_valid, resp1_ready;
    logic [127:0]         resp_block;
    logic                 core_next;
    logic [127:0]         core_block;
    logic                 core_ready;
    logic [127:0]         core_result;
    logic                 busy;
    logic                 error;
    logic [CNT_WIDTH-1:0] ops_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_core_next = 0;
    int n_req_pulse = 0;
    int n_resp1_seen = 0;

    bit core_stuck = 1'b0;
    int core_lat   = 3;

    aes_dec_arbiter #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_ready   (key_ready),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_block  (req0_block),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_block  (req1_block),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_block  (resp_block),
        .core_next   (core_next),
        .core_block  (core_block),
        .core_ready  (core_ready),
        .core_result (core_result),
        .busy        (busy),
        .error       (error),
        .ops_done    (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known AES-128 vector for key 000102..0f; any other block maps to a
    // simple bench-defined function so results are still distinguishable.
    function automatic logic [127:0] model_pt(input logic [127:0] blk);
        return (blk == CT) ? PT : (blk ^ MSK);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural decipher datapath.
    initial begin
        core_ready  = 1'b1;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_next && !core_stuck) begin
                core_ready = 1'b0;
                repeat (core_lat) @(negedge clk);
                core_result = model_pt(core_block);
                core_ready  = 1'b1;
            end
        end
    end

    // Event counters, sampled mid-cycle after inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (core_next) n_core_next++;
            if (req0_ready || req1_ready) n_req_pulse++;
            if (resp1_valid) n_resp1_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_busy",   busy,       1'b0);
        check("rst_ops",    ops_done,   0);
        check("rst_error",  error,      1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Offer a block and wait for its grant; returns at the START cycle.
    task automatic issue(input int idx, input logic [127:0] blk, input string tag);
        bit got = 1'b0;
        @(negedge clk);
        if (idx == 0) begin req0_block = blk; req0_valid = 1'b1; end
        else          begin req1_block = blk; req1_valid = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_grant"}, got, 1'b1);
        @(negedge clk);
        if (idx == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        #1;
    endtask

    task automatic wait_resp(input int idx, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if ((idx == 0 && resp0_valid) || (idx == 1 && resp1_valid)) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_rvalid"}, got, 1'b1);
    endtask

    task automatic collect(input int idx, input logic [127:0] exp_blk, input int exp_ops,
                           input string tag);
        wait_resp(idx, tag);
        check({tag, "_data"},  resp_block, exp_blk);
        check({tag, "_other"}, (idx == 0) ? resp1_valid : resp0_valid, 1'b0);
        if (idx == 0) resp0_ready = 1'b1;
        else          resp1_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        check({tag, "_ops"}, ops_done, exp_ops);
    endtask

    initial begin
        int bad;
        int pulses0;
        int cn0;
        int r1_0;
        int q_order[$];
        bit done;
        logic [127:0] held;

        reset_n     = 1'b0;
        key_ready   = 1'b1;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_block  = '0;
        req1_block  = '0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // Reset values
        #12;
        check("rst0_busy",       busy,        1'b0);
        check("rst0_core_next",  core_next,   1'b0);
        check("rst0_core_block", core_block,  128'h0);
        check("rst0_resp_block", resp_block,  128'h0);
        check("rst0_valids",     {req0_ready, req1_ready, resp0_valid, resp1_valid}, 4'b0);
        check("rst0_error",      error,       1'b0);
        check("rst0_ops",        ops_done,    0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single known-answer decipher for requester 0
        cn0  = n_core_next;
        r1_0 = n_resp1_seen;
        issue(0, CT, "t1");
        check("t1_core_next",  core_next,  1'b1);
        check("t1_core_block", core_block, CT);
        collect(0, PT, 1, "t1");
        check("t1_next_pulses", n_core_next - cn0, 1);
        check("t1_no_resp1",    n_resp1_seen - r1_0, 0);

        // Fair alternation with both requesters permanently valid
        apply_reset();
        @(negedge clk);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        pulses0     = n_req_pulse;
        req0_block  = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
        req1_block  = 128'hf0e0_d0c0_b0a0_9080_7060_5040_3020_1000;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        done        = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (req0_ready) q_order.push_back(0);
            if (req1_ready) q_order.push_back(1);
            if (resp0_valid) check("t2_resp0_data", resp_block, model_pt(req0_block));
            if (resp1_valid) check("t2_resp1_data", resp_block, model_pt(req1_block));
            if (q_order.size() >= 4 && !req0_ready && !req1_ready) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (ops_done == 4) done = 1'b1;
            @(negedge clk);
        end
        check("t2_grants", q_order.size(), 4);
        for (int i = 0; i < q_order.size() && i < 4; i++) begin
            check($sformatf("t2_order%0d", i), q_order[i], i % 2);
        end
        check("t2_ready_pulses", n_req_pulse - pulses0, 4);
        check("t2_ops", ops_done, 4);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // key_ready low blocks grants
        @(negedge clk);
        key_ready  = 1'b0;
        req0_block = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        req0_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (req0_ready || core_next || busy) bad++;
        end
        check("t3_blocked", bad, 0);
        @(negedge clk);
        key_ready = 1'b1;
        #1;
        check("t3_ready_on_key", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("t3_busy", busy, 1'b1);
        collect(0, model_pt(req0_block), 5, "t3");

        // Datapath never acknowledges -> sticky error, no response
        core_stuck = 1'b1;
        issue(1, 128'hdead_beef_0000_1111_2222_3333_4444_5555, "t4");
        check("t4_core_next", core_next, 1'b1);
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            if (resp0_valid || resp1_valid) bad++;
            if (k == 3) check("t4_err_early", error, 1'b0);
            if (k == 5) begin
                check("t4_err_set",   error, 1'b1);
                check("t4_idle",      busy,  1'b0);
            end
        end
        check("t4_no_resp", bad, 0);
        core_stuck = 1'b0;
        issue(0, CT, "t4b");
        collect(0, PT, 6, "t4b");
        check("t4_err_sticky", error, 1'b1);

        // Response back-pressure holds off the other requester
        issue(0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, "t5");
        wait_resp(0, "t5");
        held       = resp_block;
        check("t5_data", held, model_pt(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210));
        req1_block = 128'haaaa_bbbb_cccc_dddd_eeee_ffff_0000_9999;
        req1_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (req1_ready || !resp0_valid || resp_block !== held) bad++;
        end
        check("t5_stall", bad, 0);
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        check("t5_ops",        ops_done,   7);
        check("t5_req1_grant", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        collect(1, model_pt(req1_block), 8, "t5b");

        // Reset in the middle of RUN
        issue(0, 128'h7777_6666_5555_4444_3333_2222_1111_0000, "t6");
        repeat (2) @(negedge clk);
        #1;
        check("t6_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_busy",      busy,      1'b0);
        check("t6_core_next", core_next, 1'b0);
        check("t6_hs",        {req0_ready, req1_ready, resp0_valid, resp1_valid}, 4'b0);
        check("t6_blocks",    {core_block, resp_block} == 256'h0, 1'b1);
        check("t6_error",     error,     1'b0);
        check("t6_ops",       ops_done,  0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        issue(0, CT, "t6b");
        collect(0, PT, 1, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
